// File: rtl/uart_rx_frame_parser.sv
// ============================================================================
// Module   : uart_rx_frame_parser
// Brief    : Parses SYNC/LEN/payload/CSUM frames from a UART_RX byte stream.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_frame_parser #(
  parameter int             N       = 8,
  parameter logic [N-1:0]   SYNC    = 'h55,
  parameter int             MAX_LEN = 16,
  parameter int             TIMEOUT = 50000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] in_data,
  input  logic         in_ready,
  output logic [N-1:0] out_data,
  output logic         out_valid,
  output logic         out_last,
  output logic         frame_done,
  output logic         frame_err,
  output logic [1:0]   err_code,
  output logic         busy
);

  localparam int            c_TW      = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 2;
  localparam logic [c_TW-1:0] c_TLIM  = c_TW'(TIMEOUT - 1);
  localparam logic [N:0]    c_MAX_LEN = (N + 1)'(MAX_LEN);

  localparam logic [1:0] c_ERR_CSUM    = 2'd1;
  localparam logic [1:0] c_ERR_LEN     = 2'd2;
  localparam logic [1:0] c_ERR_TIMEOUT = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LEN     = 2'd1,
    S_PAYLOAD = 2'd2,
    S_CSUM    = 2'd3
  } state_t;

  state_t          r_state,      w_state_nxt;
  logic            r_ready_d;
  logic [N-1:0]    r_len,        w_len_nxt;
  logic [N-1:0]    r_csum,       w_csum_nxt;
  logic [N-1:0]    r_cnt,        w_cnt_nxt;
  logic [c_TW-1:0] r_tcnt,       w_tcnt_nxt;
  logic [N-1:0]    r_out_data,   w_out_data_nxt;
  logic            r_out_valid,  w_out_valid_nxt;
  logic            r_out_last,   w_out_last_nxt;
  logic            r_frame_done, w_frame_done_nxt;
  logic            r_frame_err,  w_frame_err_nxt;
  logic [1:0]      r_err_code,   w_err_code_nxt;

  logic w_accept;
  logic w_expire;

  // One byte per rising edge of the receiver's ready level.
  assign w_accept = in_ready & ~r_ready_d;
  assign w_expire = (r_state != S_IDLE) & ~w_accept & (r_tcnt == c_TLIM);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_ready_d    <= 1'b0;
      r_len        <= '0;
      r_csum       <= '0;
      r_cnt        <= '0;
      r_tcnt       <= '0;
      r_out_data   <= '0;
      r_out_valid  <= 1'b0;
      r_out_last   <= 1'b0;
      r_frame_done <= 1'b0;
      r_frame_err  <= 1'b0;
      r_err_code   <= 2'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_ready_d    <= in_ready;
      r_len        <= w_len_nxt;
      r_csum       <= w_csum_nxt;
      r_cnt        <= w_cnt_nxt;
      r_tcnt       <= w_tcnt_nxt;
      r_out_data   <= w_out_data_nxt;
      r_out_valid  <= w_out_valid_nxt;
      r_out_last   <= w_out_last_nxt;
      r_frame_done <= w_frame_done_nxt;
      r_frame_err  <= w_frame_err_nxt;
      r_err_code   <= w_err_code_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_len_nxt        = r_len;
    w_csum_nxt       = r_csum;
    w_cnt_nxt        = r_cnt;
    w_tcnt_nxt       = '0;
    w_out_data_nxt   = r_out_data;
    w_out_valid_nxt  = 1'b0;
    w_out_last_nxt   = 1'b0;
    w_frame_done_nxt = 1'b0;
    w_frame_err_nxt  = 1'b0;
    w_err_code_nxt   = r_err_code;

    if (r_state != S_IDLE) begin
      w_tcnt_nxt = r_tcnt + 1'b1;
    end

    // An accepted byte in the expiry cycle keeps the frame alive.
    if (w_expire) begin
      w_tcnt_nxt      = '0;
      w_state_nxt     = S_IDLE;
      w_frame_err_nxt = 1'b1;
      w_err_code_nxt  = c_ERR_TIMEOUT;
    end else if (w_accept) begin
      w_tcnt_nxt = '0;
      case (r_state)
        S_IDLE: begin
          if (in_data == SYNC) begin
            w_state_nxt = S_LEN;
          end
        end
        S_LEN: begin
          w_len_nxt  = in_data;
          w_csum_nxt = in_data;
          w_cnt_nxt  = '0;
          if ({1'b0, in_data} > c_MAX_LEN) begin
            w_state_nxt     = S_IDLE;
            w_frame_err_nxt = 1'b1;
            w_err_code_nxt  = c_ERR_LEN;
          end else if (in_data == '0) begin
            w_state_nxt = S_CSUM;
          end else begin
            w_state_nxt = S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          w_out_data_nxt  = in_data;
          w_out_valid_nxt = 1'b1;
          w_csum_nxt      = r_csum + in_data;
          w_cnt_nxt       = r_cnt + 1'b1;
          if (r_cnt == r_len - 1'b1) begin
            w_out_last_nxt = 1'b1;
            w_state_nxt    = S_CSUM;
          end
        end
        S_CSUM: begin
          w_state_nxt = S_IDLE;
          if (in_data == r_csum) begin
            w_frame_done_nxt = 1'b1;
          end else begin
            w_frame_err_nxt = 1'b1;
            w_err_code_nxt  = c_ERR_CSUM;
          end
        end
      endcase
    end
  end

  assign out_data   = r_out_data;
  assign out_valid  = r_out_valid;
  assign out_last   = r_out_last;
  assign frame_done = r_frame_done;
  assign frame_err  = r_frame_err;
  assign err_code   = r_err_code;
  assign busy       = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: doc/uart_rx_frame_parser.md
Name: uart_rx_frame_parser

Overview:
- Sits directly downstream of UART_RX and consumes its received-byte output (q / ready).
- Extracts framed packets from the byte stream: SYNC, LEN, LEN payload bytes, CSUM.
- Forwards payload bytes as they arrive and reports frame completion or error with a code.
- Runs on the same 50 MHz clock as the receiver.

Parameters:
- N, 8, byte width; must match UART_RX N.
- SYNC, 8'h55, start-of-frame marker.
- MAX_LEN, 16, largest legal LEN value.
- TIMEOUT, 50000, maximum clk cycles allowed between accepted bytes inside a frame (1 ms at 50 MHz).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous reset, active-high.
- in_data  in  N  received byte; connects to UART_RX q.
- in_ready  in  1  receiver byte-valid level; connects to UART_RX ready.
- out_data  out  N  forwarded payload byte.
- out_valid  out  1  one-cycle strobe, out_data valid.
- out_last  out  1  high with out_valid on the final payload byte.
- frame_done  out  1  one-cycle strobe, frame passed checksum.
- frame_err  out  1  one-cycle strobe, frame aborted.
- err_code  out  2  valid with frame_err: 1 = checksum mismatch, 2 = LEN > MAX_LEN, 3 = timeout.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset:
  - State IDLE.
  - All outputs 0.
  - Edge register, checksum, byte counter and timeout counter cleared.
  - A reset asserted mid-frame discards the frame; no strobes are issued for it.
- Byte acceptance:
  - ready_d registers in_ready.
  - A byte is accepted in a cycle where in_ready & ~ready_d; in_data is sampled in that cycle.
  - A level held high yields exactly one byte.
  - Every registered output responds one cycle after acceptance.
- FSM states:
  - IDLE: accepted byte == SYNC -> LEN. Any other byte is ignored, with no strobe.
  - LEN:
    - Store len and set csum = byte.
    - byte > MAX_LEN -> frame_err, err_code 2, -> IDLE.
    - byte == 0 -> CSUM.
    - Otherwise -> PAYLOAD with cnt = 0.
  - PAYLOAD:
    - Each accepted byte: out_data = byte, out_valid = 1, csum = csum + byte (mod 2^N), cnt++.
    - On the byte where cnt == len-1: out_last = 1 -> CSUM.
  - CSUM:
    - Accepted byte == csum -> frame_done. Otherwise frame_err with err_code 1.
    - Either way -> IDLE.
- Checksum: N-bit wrap-around sum of LEN and all payload bytes; SYNC is excluded.
- Timeout:
  - The counter runs only while busy and clears on every accepted byte.
  - On reaching TIMEOUT-1 with no accepted byte: frame_err, err_code 3, -> IDLE.
  - If a byte is accepted in the same cycle the counter would expire, the byte wins and the counter clears.
- Strobes:
  - frame_done and frame_err are mutually exclusive and each lasts exactly 1 cycle.
  - err_code holds its value until the next frame_err. It clears only on reset.
- Error recovery:
  - Payload already forwarded is not retracted; the consumer discards it on frame_err.
  - A SYNC value arriving inside PAYLOAD or CSUM is treated as data, with no resync.
- Back-to-back frames: a SYNC byte accepted in the cycle right after the CSUM byte is handled normally.

Test Plan:
- Good frame: 55 03 11 22 33 69 -> out_valid x3 with data 11, 22, 33; out_last on 33; frame_done one cycle after the 69 byte; frame_err stays 0.
- Bad checksum: 55 03 11 22 33 68 -> three payload strobes, then frame_err with err_code 1, busy low on the next cycle.
- Zero and oversize length: 55 00 00 -> frame_done with no out_valid. 55 20 -> frame_err with err_code 2 and return to IDLE.
- Noise and level hold:
  - Send A5, 00, FF before a valid frame -> no strobes, then a normal frame_done.
  - Hold in_ready high for 10 cycles on one byte -> exactly one byte accepted.
- Timeout: 55 03 11, then idle for 50000 cycles -> frame_err with err_code 3 exactly TIMEOUT cycles after the 11 byte; a following good frame completes correctly.
- Reset mid-frame: assert rst for 1 cycle after 55 03 11 -> busy 0 and outputs 0; the following 22 33 bytes are ignored; a fresh good frame passes.
- End-to-end: drive the frame through UART_TX -> UART_RX (STOP=0) into this block -> same results as the good-frame case.
